// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants.
//   TIME_W / DIGIT_W : width of a full BCD time word and of one BCD digit
//   bcd_time_t       : {minutes, sec_msb, sec_lsb, tenths, hundredths}
//   lap_state_t      : lap_recorder controller states
package stopwatch_pkg;

  localparam int TIME_W  = 20;
  localparam int DIGIT_W = 4;

  typedef struct packed {
    logic [DIGIT_W-1:0] minutes;
    logic [DIGIT_W-1:0] sec_msb;
    logic [DIGIT_W-1:0] sec_lsb;
    logic [DIGIT_W-1:0] tenths;
    logic [DIGIT_W-1:0] hundredths;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RECALL  = 2'd2,
    CLEAR   = 2'd3
  } lap_state_t;

endpackage

// File: rtl/lap_ram.sv
// Lap storage: DEPTH x TIME_W single-port RAM, synchronous write,
// registered read.
//   clk     : clock
//   rst     : synchronous active-high reset, clears only the read register
//   we      : write enable, wr_data stored at addr
//   re      : read enable, mem[addr] loaded into rd_data
//   addr    : shared read/write address
//   wr_data : write data
//   rd_data : read register; holds its value while re is low
module lap_ram
  import stopwatch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [TIME_W-1:0] wr_data,
  output logic [TIME_W-1:0] rd_data
);

  logic [TIME_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

  // Read register only moves on an explicit read, so writes during capture
  // or clear never disturb the last recalled value.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[addr];
  end

endmodule

// File: rtl/lap_recorder.sv
// Lap-time capture and recall controller (100 Hz domain).
// Captures time_in on each lap into a circular buffer and plays laps back,
// oldest first, one per recall.
//   clk       : stopwatch clock
//   rst       : synchronous active-high reset
//   lap       : one-cycle capture request
//   time_in   : current BCD time from the timer
//   recall    : one-cycle request for the next stored lap
//   clear     : one-cycle request to erase all laps
//   lap_time  : recalled lap value
//   lap_valid : one-cycle strobe marking new lap_time / lap_index
//   lap_index : position of recalled entry, 0 = oldest
//   lap_count : number of stored entries, 0..DEPTH
//   empty     : lap_count == 0
//   full      : lap_count == DEPTH
//   overflow  : sticky, a lap arrived while full
//   busy      : controller not in IDLE
// Build option: define LAP_OVERWRITE_EN to let a lap while full overwrite
// the oldest entry; otherwise such a lap is discarded.
module lap_recorder
  import stopwatch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lap,
  input  logic [TIME_W-1:0] time_in,
  input  logic              recall,
  input  logic              clear,
  output logic [TIME_W-1:0] lap_time,
  output logic              lap_valid,
  output logic [AW-1:0]     lap_index,
  output logic [AW:0]       lap_count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              busy
);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  lap_state_t        state_q, state_d;
  logic              pend_q;
  logic [AW-1:0]     wr_ptr, rd_ofs, clr_cnt;
  bcd_time_t         cap_time_p0;
  logic [AW:0]       count_d;

  logic              lap_req, take_clear, take_lap, take_recall;
  logic              cap_write, clr_last;
  logic [AW-1:0]     rd_addr;

  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [TIME_W-1:0] ram_wdata;

  // A pending lap competes in IDLE exactly like a fresh lap request.
  always_comb begin
    lap_req     = lap | pend_q;
    take_clear  = (state_q == IDLE) && clear;
    take_lap    = (state_q == IDLE) && !clear && lap_req;
    take_recall = (state_q == IDLE) && !clear && !lap_req && recall && !empty;
    clr_last    = (clr_cnt == LAST_ADDR);
    // Oldest entry sits lap_count behind the write pointer; when full the
    // low bits of lap_count are zero and this lands on wr_ptr itself.
    rd_addr     = wr_ptr - lap_count[AW-1:0] + rd_ofs;
`ifdef LAP_OVERWRITE_EN
    cap_write   = 1'b1;
`else
    cap_write   = !full;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_clear)       state_d = CLEAR;
        else if (take_lap)    state_d = CAPTURE;
        else if (take_recall) state_d = RECALL;
      end
      CAPTURE: state_d = IDLE;
      RECALL:  state_d = IDLE;
      CLEAR:   if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = cap_time_p0;
    case (state_q)
      CAPTURE: begin
        ram_we   = cap_write;
        ram_addr = wr_ptr;
      end
      RECALL:  ram_re = 1'b1;
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = lap_count;
    if (state_q == CAPTURE && lap_count != DEPTH_C) count_d = lap_count + (AW+1)'(1);
    if (state_q == CLEAR && clr_last)               count_d = '0;
  end

  // Stage p0: time sample taken in the accepting IDLE cycle.
  always_ff @(posedge clk) begin
    if (take_lap) cap_time_p0 <= bcd_time_t'(time_in);
  end

  // Stage p1: write / read issued, counters and flags committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ofs    <= '0;
      clr_cnt   <= '0;
      lap_count <= '0;
      lap_index <= '0;
      lap_valid <= 1'b0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= (state_d != IDLE);
      lap_count <= count_d;
      empty     <= (count_d == '0);
      full      <= (count_d == DEPTH_C);
      lap_valid <= (state_q == RECALL);

      // One-deep: a set flag just absorbs further laps. Leaving IDLE always
      // consumes it, either served or dropped under a clear.
      if ((state_q == CAPTURE || state_q == RECALL) && lap) pend_q <= 1'b1;
      else if (state_q == IDLE)                             pend_q <= 1'b0;

      case (state_q)
        CAPTURE: begin
          rd_ofs <= '0;
          if (cap_write) wr_ptr   <= wr_ptr + AW'(1);
          if (full)      overflow <= 1'b1;
        end
        RECALL: begin
          lap_index <= rd_ofs;
          if ({1'b0, rd_ofs} == lap_count - (AW+1)'(1)) rd_ofs <= '0;
          else                                         rd_ofs <= rd_ofs + AW'(1);
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_last) begin
            wr_ptr   <= '0;
            rd_ofs   <= '0;
            overflow <= 1'b0;
          end
        end
        default: clr_cnt <= '0;
      endcase
    end
  end

  lap_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .re      (ram_re),
    .addr    (ram_addr),
    .wr_data (ram_wdata),
    .rd_data (lap_time)
  );

endmodule

// File: tb/tb_lap_recorder.sv
module tb_lap_recorder;
  import stopwatch_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk = 1'b0;
  logic              rst, lap, recall, clear;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] lap_time;
  logic              lap_valid, empty, full, overflow, busy;
  logic [AW-1:0]     lap_index;
  logic [AW:0]       lap_count;

  always #5 clk = ~clk;

  lap_recorder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lap(lap), .time_in(time_in), .recall(recall),
    .clear(clear), .lap_time(lap_time), .lap_valid(lap_valid),
    .lap_index(lap_index), .lap_count(lap_count), .empty(empty),
    .full(full), .overflow(overflow), .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [TIME_W-1:0] t; int idx; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: list of stored laps, oldest first.
  logic [TIME_W-1:0] m_laps[$];
  int                m_ofs = 0;
  bit                m_ovf = 0;
  logic [TIME_W-1:0] m_time = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (lap_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got lap_time 0x%0h index %0d, expected no strobe", lap_time, lap_index);
      end else begin
        mon_e = sb.pop_front();
        chk("recall_time", 32'(lap_time), 32'(mon_e.t));
        chk("recall_index", 32'(lap_index), 32'(mon_e.idx));
      end
    end
  end

  task automatic m_lap(input logic [TIME_W-1:0] v);
    if (m_laps.size() == DEPTH) begin
      m_ovf = 1;
`ifdef LAP_OVERWRITE_EN
      void'(m_laps.pop_front());
      m_laps.push_back(v);
`endif
    end else begin
      m_laps.push_back(v);
    end
    m_ofs = 0;
  endtask

  task automatic m_recall(output bit ev);
    exp_t e;
    ev = 0;
    if (m_laps.size() != 0) begin
      ev     = 1;
      e.t    = m_laps[m_ofs];
      e.idx  = m_ofs;
      sb.push_back(e);
      m_time = e.t;
      m_ofs  = (m_ofs + 1) % m_laps.size();
    end
  endtask

  task automatic m_clear();
    m_laps.delete();
    m_ofs = 0;
    m_ovf = 0;
  endtask

  task automatic m_reset();
    m_clear();
    m_time = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"},    32'(lap_count), 32'(m_laps.size()));
    chk({tag, "_empty"},    32'(empty),     32'(m_laps.size() == 0));
    chk({tag, "_full"},     32'(full),      32'(m_laps.size() == DEPTH));
    chk({tag, "_overflow"}, 32'(overflow),  32'(m_ovf));
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_time"},     32'(lap_time),  32'(m_time));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    m_reset();
    chk("rst_valid", 32'(lap_valid), 32'd0);
    chk("rst_index", 32'(lap_index), 32'd0);
    check_state("rst");
  endtask

  task automatic do_lap(input logic [TIME_W-1:0] v);
    int old;
    old     = m_laps.size();
    time_in = v;
    lap     = 1'b1;
    cyc();
    lap     = 1'b0;
    chk("lap_busy_n1", 32'(busy), 32'd1);
    chk("lap_count_n1", 32'(lap_count), 32'(old));
    m_lap(v);
    wait_idle();
    check_state("lap");
  endtask

  task automatic do_recall();
    bit ev;
    recall = 1'b1;
    cyc();
    recall = 1'b0;
    m_recall(ev);
    chk("recall_valid_m1", 32'(lap_valid), 32'd0);
    chk("recall_busy_m1", 32'(busy), 32'(ev));
    cyc();
    chk("recall_valid_m2", 32'(lap_valid), 32'(ev));
    wait_idle();
    check_state("recall");
  endtask

  // Recall accepted in M, lap in M+1: lap goes pending and is served after.
  task automatic do_recall_lap(input logic [TIME_W-1:0] v, input bit chk_inc);
    bit ev;
    int old;
    recall = 1'b1;
    cyc();
    recall  = 1'b0;
    m_recall(ev);
    time_in = v;
    lap     = 1'b1;
    cyc();
    lap = 1'b0;
    chk("pend_valid_m2", 32'(lap_valid), 32'(ev));
    old = m_laps.size();
    m_lap(v);
    cyc();
    chk("pend_busy_m3", 32'(busy), 32'd1);
    cyc();
    if (chk_inc) chk("pend_count_inc", 32'(lap_count), 32'(old + 1));
    check_state("pend");
  endtask

  task automatic do_clear(input bit with_lap);
    int n = 0;
    clear   = 1'b1;
    lap     = with_lap;
    time_in = 20'h0_5555;
    cyc();
    clear = 1'b0;
    lap   = 1'b0;
    m_clear();
    while (busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    chk("clear_busy_cycles", 32'(n), 32'(DEPTH));
    check_state("clear");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lap = 1'b0; recall = 1'b0; clear = 1'b0; time_in = '0;
    cyc();
    do_reset();

    // Recall while empty: ignored, lap_time held.
    do_recall();

    // Three laps, four recalls with wrap back to the oldest.
    do_lap(20'h0_1234);
    do_lap(20'h0_2500);
    do_lap(20'h1_0399);
    repeat (4) do_recall();

    // Lap in the cycle after an accepted recall.
    do_recall_lap(20'h0_4711, 1'b1);
    do_recall();

    // Clear with a simultaneous lap: lap dropped, then recall gives nothing.
    do_clear(1'b1);
    do_recall();

    // 17 laps into 16 entries.
    for (int i = 1; i <= 17; i++) do_lap(20'(i));
    do_recall();
    do_recall();

    // Reset in the 5th cycle of CLEAR.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (4) cyc();
    chk("clear5_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_reset();
    chk("midclr_valid", 32'(lap_valid), 32'd0);
    chk("midclr_index", 32'(lap_index), 32'd0);
    check_state("midclr");
    do_lap(20'h0_0042);
    do_recall();

    // Randomized traffic.
    for (int k = 0; k < 250; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)                              do_lap(20'($urandom));
      else if (r < 88)                         do_recall();
      else if (r < 91)                         do_clear(r[0]);
      else if (m_laps.size() != 0)             do_recall_lap(20'($urandom), 1'b0);
      else                                     do_recall();
    end

    cyc();
    cyc();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lap_recorder.md
# lap_recorder

Lap-time capture and recall controller for the stopwatch. It samples the five-digit BCD time from the timer on each debounced lap trigger and stores it in a circular buffer. On request it plays the stored laps back, oldest first, to the LCD controller. It sits between the state machine's `lap_trigger` output, the timer's digit outputs and the LCD controller's display inputs, all on the 100 Hz clock domain.

## Interface
- `DEPTH`, 16, number of lap entries; power of two, 2..64
- `AW`, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
- `clk` input 1: single clock, the 100 Hz stopwatch clock
- `rst` input 1: synchronous, active-high reset
- `lap` input 1: one-cycle capture request
- `time_in` input 20: {minutes, sec_msb, sec_lsb, tenths, hundredths}, 4 bits BCD each
- `recall` input 1: one-cycle request to output the next stored lap
- `clear` input 1: one-cycle request to erase all laps
- `lap_time` output 20: recalled lap value
- `lap_valid` output 1: one-cycle strobe, `lap_time` and `lap_index` are new
- `lap_index` output AW: recalled entry's position, 0 = oldest
- `lap_count` output AW+1: entries stored, 0..DEPTH
- `empty`, `full` output 1: `lap_count`==0 / ==DEPTH
- `overflow` output 1: sticky; a lap arrived while the buffer was full
- `busy` output 1: high whenever the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: accepts requests, with priority `clear` > `lap` > `recall`. The lower-priority simultaneous requests are dropped, apart from the pending-lap rule below.
  - CAPTURE: one cycle. Writes the captured time.
  - RECALL: one cycle. Performs a registered read.
  - CLEAR: DEPTH cycles. Writes zero to every address in ascending order.
- Capture:
  - `time_in` is registered in the cycle `lap` is accepted.
  - The value is written at `wr_ptr`, then `wr_ptr` advances modulo DEPTH.
  - `lap_count` increments, saturating at DEPTH.
- Oldest entry address is `wr_ptr - lap_count` modulo DEPTH.
- Recall:
  - Reads address (oldest + `rd_ofs`) modulo DEPTH.
  - `lap_index` = `rd_ofs`.
  - `rd_ofs` then advances and wraps to 0 after `lap_count`-1.
- Recall while `empty`: ignored. No strobe, no state change, and `lap_time` is held.
- Any capture or clear resets `rd_ofs` to 0.
- Pending lap: a `lap` arriving in CAPTURE or RECALL sets a one-deep pending flag, which is served on the first IDLE cycle. Further laps while the flag is set are dropped.
  - `lap` during CLEAR is dropped.
  - `recall` outside IDLE is dropped.
- End of CLEAR: `wr_ptr`, `rd_ofs`, `lap_count` and `overflow` go to 0.
- `rst` at any point, including mid-CLEAR:
  - Outputs: `lap_time`=0, `lap_valid`=0, `lap_index`=0, `lap_count`=0, `empty`=1, `full`=0, `overflow`=0, `busy`=0.
  - FSM returns to IDLE and the pending flag clears.
  - Buffer contents are not reset.
- BCD digits are stored unchecked. The block does no arithmetic on time values.

## Timing
- `lap` accepted in cycle N:
  - Write occurs on the edge ending N+1.
  - `lap_count`, `full` and `empty` update in cycle N+2.
  - `busy` is high in N+1.
- `recall` accepted in cycle M:
  - `lap_time` and `lap_index` update in M+2.
  - `lap_valid` is high for exactly cycle M+2.
- Back-to-back: a new request is accepted no earlier than two cycles after the previous one.
- `clear` accepted in cycle K:
  - `busy` is high for K+1..K+DEPTH.
  - Counters read 0 and the FSM is IDLE in K+DEPTH+1.
- `empty`, `full` and `busy` are registered (combinational decode of registered state is acceptable only if glitch-free).

## Configuration
- `LAP_OVERWRITE_EN` defined: a lap while `full` overwrites the oldest entry.
  - `wr_ptr` advances and `lap_count` stays DEPTH.
  - `overflow` sets.
- Not defined: a lap while `full` is discarded.
  - No write, and pointers are unchanged.
  - `overflow` sets.
  - The FSM still spends the CAPTURE cycle.

## Structure
- Package `stopwatch_pkg` holds:
  - `TIME_W`=20 and `DIGIT_W`=4.
  - A packed typedef `bcd_time_t` with fields minutes, sec_msb, sec_lsb, tenths, hundredths.
  - Enum `lap_state_t` with IDLE, CAPTURE, RECALL, CLEAR.
- Sub-module `lap_ram`: DEPTH x TIME_W, single port, synchronous write, registered read. It is written as inferable block/distributed RAM.
- The FSM, pointers, counters and flags live in `lap_recorder`.

## Test plan
- Reset, then capture 3 laps (times 0:12.34, 0:25.00, 1:03.99) and recall 4 times. Required: `lap_time` = 0x01234, 0x02500, 0x10399, 0x01234; `lap_index` = 0,1,2,0; `lap_count`=3.
- With DEPTH=16, capture 17 laps (values 1..17). Required: `full`=1 and `overflow`=1. The first recall returns 2 with the macro defined, or 1 without it.
- `clear` and `lap` in the same cycle. Required: the lap is dropped, `busy` is high for 16 cycles, then `lap_count`=0 and `empty`=1, and a subsequent recall gives no strobe.
- `lap` in the cycle after an accepted `recall`. Required: the recalled value strobes in M+2, the pending lap is written afterward, and `lap_count` increments by 1.
- `recall` while `empty`. Required: `lap_valid` stays 0 and `lap_time` is unchanged.
- Assert `rst` in the 5th cycle of CLEAR. Required: the next cycle shows `busy`=0 and all outputs at reset values, and a lap then captures normally at index 0.
